// File: rtl/conv_3x3_seq_ctrl_pkg.sv
// Shared types and constants for the 3x3 convolution sequencer.
// FSM encoding, kernel geometry and width helpers.
package conv_3x3_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_OUT,
    S_FIN
  } state_t;

  localparam int TAPS  = 9;
  localparam int KSIZE = 3;

  // Bits needed to hold the values 0..n.
  function automatic int bits_for(input int n);
    int b;
    b = 1;
    while ((1 << b) <= n) b = b + 1;
    return b;
  endfunction

endpackage

// File: rtl/conv_win_addr_gen.sv
// Window/tap address generator for the 3x3 sequencer.
// Builds feature addresses from base + offset registers, no multiplier.
module conv_win_addr_gen
  import conv_3x3_seq_ctrl_pkg::*;
#(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_tap_adv,
  input  logic              i_pix_adv,
  output logic [ADDR_W-1:0] o_fm_raddr,
  output logic [3:0]        o_wt_raddr,
  output logic [ADDR_W-1:0] o_out_addr,
  output logic              o_last_tap,
  output logic              o_last_pix
);

  localparam int RW = bits_for(IMG_H);
  localparam int CW = bits_for(IMG_W);

  localparam logic [1:0]        L_KMAX  = 2'(KSIZE - 1);
  localparam logic [RW-1:0]     L_LAST_R = RW'(IMG_H - KSIZE);
  localparam logic [CW-1:0]     L_LAST_C = CW'(IMG_W - KSIZE);
  localparam logic [RW-1:0]     L_R_ONE  = RW'(1);
  localparam logic [CW-1:0]     L_C_ONE  = CW'(1);
  localparam logic [ADDR_W-1:0] L_A_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] L_ROW_STEP  = ADDR_W'(IMG_W - KSIZE + 1);
  localparam logic [ADDR_W-1:0] L_WRAP_STEP = ADDR_W'(KSIZE);

  logic [RW-1:0]     r_row;
  logic [CW-1:0]     r_col;
  logic [1:0]        r_kx;
  logic [1:0]        r_ky;
  logic [3:0]        r_k;
  logic [ADDR_W-1:0] r_win_base;
  logic [ADDR_W-1:0] r_tap_off;
  logic [ADDR_W-1:0] r_out_idx;

  logic w_last_tap;
  logic w_last_pix;

  assign w_last_tap = (r_ky == L_KMAX) && (r_kx == L_KMAX);
  assign w_last_pix = (r_row == L_LAST_R) && (r_col == L_LAST_C);

  assign o_fm_raddr = r_win_base + r_tap_off;
  assign o_wt_raddr = r_k;
  assign o_out_addr = r_out_idx;
  assign o_last_tap = w_last_tap;
  assign o_last_pix = w_last_pix;

  // Tap walk inside a window: kx fastest, offset steps to next row on wrap.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_kx      <= '0;
      r_ky      <= '0;
      r_k       <= '0;
      r_tap_off <= '0;
    end else if (i_tap_adv) begin
      if (w_last_tap) begin
        r_kx      <= '0;
        r_ky      <= '0;
        r_k       <= '0;
        r_tap_off <= '0;
      end else if (r_kx == L_KMAX) begin
        r_kx      <= '0;
        r_ky      <= r_ky + 2'd1;
        r_k       <= r_k + 4'd1;
        r_tap_off <= r_tap_off + L_ROW_STEP;
      end else begin
        r_kx      <= r_kx + 2'd1;
        r_k       <= r_k + 4'd1;
        r_tap_off <= r_tap_off + L_A_ONE;
      end
    end
  end

  // Window walk: column first, base jumps over the right border on wrap.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_row      <= '0;
      r_col      <= '0;
      r_win_base <= '0;
      r_out_idx  <= '0;
    end else if (i_pix_adv) begin
      r_out_idx <= r_out_idx + L_A_ONE;
      if (r_col == L_LAST_C) begin
        r_col      <= '0;
        r_row      <= r_row + L_R_ONE;
        r_win_base <= r_win_base + L_WRAP_STEP;
      end else begin
        r_col      <= r_col + L_C_ONE;
        r_win_base <= r_win_base + L_A_ONE;
      end
    end
  end

endmodule

// File: rtl/conv_3x3_seq_ctrl.sv
// Sequencer for the serial 3x3 convolution MAC.
// Fetches 9 taps per window, waits out MAC latency, hands result out.
module conv_3x3_seq_ctrl
  import conv_3x3_seq_ctrl_pkg::*;
#(
  parameter int IMG_W   = 8,
  parameter int IMG_H   = 8,
  parameter int ADDR_W  = 6,
  parameter int MAC_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] fm_raddr,
  input  logic [7:0]        fm_rdata,
  output logic [3:0]        wt_raddr,
  input  logic [7:0]        wt_rdata,
  output logic              mac_accum_clr,
  output logic [7:0]        mac_data,
  output logic [7:0]        mac_weight,
  input  logic [7:0]        mac_ans,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic [ADDR_W-1:0] out_addr
);

  localparam int DW = bits_for(MAC_LAT);
  localparam logic [DW-1:0] L_DRAIN_END = DW'(MAC_LAT);
  localparam logic [DW-1:0] L_D_ONE     = DW'(1);

  state_t r_state;
  state_t w_next;

  logic [DW-1:0] r_drain;
  logic          r_tap_vld;
  logic          r_tap0;
  logic [7:0]    r_out_data;

  logic w_clr;
  logic w_tap_adv;
  logic w_pix_adv;
  logic w_load;
  logic w_drain_last;
  logic w_last_tap;
  logic w_last_pix;
  logic [3:0] w_wt_raddr;

  conv_win_addr_gen #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ADDR_W (ADDR_W)
  ) u_addr (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_clr),
    .i_tap_adv  (w_tap_adv),
    .i_pix_adv  (w_pix_adv),
    .o_fm_raddr (fm_raddr),
    .o_wt_raddr (w_wt_raddr),
    .o_out_addr (out_addr),
    .o_last_tap (w_last_tap),
    .o_last_pix (w_last_pix)
  );

  assign wt_raddr     = w_wt_raddr;
  assign w_drain_last = (r_drain == L_DRAIN_END);

  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_FIN);
  assign out_valid = (r_state == S_OUT);
  assign out_data  = r_out_data;

  assign mac_accum_clr = r_tap0;
  assign mac_data      = r_tap_vld ? fm_rdata : 8'd0;
  assign mac_weight    = r_tap_vld ? wt_rdata : 8'd0;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next state and per-state strobes.
  always_comb begin
    w_next    = r_state;
    w_clr     = 1'b0;
    w_tap_adv = 1'b0;
    w_pix_adv = 1'b0;
    w_load    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_clr  = 1'b1;
          w_next = S_FETCH;
        end
      end
      S_FETCH: begin
        w_tap_adv = 1'b1;
        if (w_last_tap) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_drain_last) begin
          w_load = 1'b1;
          w_next = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          w_pix_adv = 1'b1;
          w_next    = w_last_pix ? S_FIN : S_FETCH;
        end
      end
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Drain counter: tap-8 data cycle plus MAC_LAT cycles of latency.
  always_ff @(posedge clk) begin
    if (rst || r_state != S_DRAIN) r_drain <= '0;
    else if (w_drain_last)         r_drain <= '0;
    else                           r_drain <= r_drain + L_D_ONE;
  end

  // Delay issue flags by the SRAM read latency to align with returned data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tap_vld <= 1'b0;
      r_tap0    <= 1'b0;
    end else begin
      r_tap_vld <= (r_state == S_FETCH);
      r_tap0    <= (r_state == S_FETCH) && (w_wt_raddr == 4'd0);
    end
  end

  // Capture the MAC result as the drain completes; held through OUT.
  always_ff @(posedge clk) begin
    if (rst)         r_out_data <= 8'd0;
    else if (w_load) r_out_data <= mac_ans;
  end

endmodule

// File: tb/tb_conv_3x3_seq_ctrl.sv
// Testbench for conv_3x3_seq_ctrl: 4x4 and 5x3 instances,
// SRAM and MAC models, table vectors, corner sequences, random passes.
module tb_conv_3x3_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] fm_mem [64];
  logic [7:0] wt_mem [16];

  // Instance A: 4x4
  logic       startA = 1'b0, ordyA = 1'b1;
  logic       busyA, doneA, clrA, ovA;
  logic [5:0] fraA, oaA;
  logic [3:0] wraA;
  logic [7:0] frdA, wrdA, mdA, mwA, ansA, accA, odA;

  // Instance B: 5x3
  logic       startB = 1'b0, ordyB = 1'b1;
  logic       busyB, doneB, clrB, ovB;
  logic [5:0] fraB, oaB;
  logic [3:0] wraB;
  logic [7:0] frdB, wrdB, mdB, mwB, ansB, accB, odB;

  conv_3x3_seq_ctrl #(.IMG_W(4), .IMG_H(4), .ADDR_W(6), .MAC_LAT(2)) u_dut_a (
    .clk(clk), .rst(rst), .start(startA), .busy(busyA), .done(doneA),
    .fm_raddr(fraA), .fm_rdata(frdA), .wt_raddr(wraA), .wt_rdata(wrdA),
    .mac_accum_clr(clrA), .mac_data(mdA), .mac_weight(mwA), .mac_ans(ansA),
    .out_valid(ovA), .out_ready(ordyA), .out_data(odA), .out_addr(oaA));

  conv_3x3_seq_ctrl #(.IMG_W(5), .IMG_H(3), .ADDR_W(6), .MAC_LAT(2)) u_dut_b (
    .clk(clk), .rst(rst), .start(startB), .busy(busyB), .done(doneB),
    .fm_raddr(fraB), .fm_rdata(frdB), .wt_raddr(wraB), .wt_rdata(wrdB),
    .mac_accum_clr(clrB), .mac_data(mdB), .mac_weight(mwB), .mac_ans(ansB),
    .out_valid(ovB), .out_ready(ordyB), .out_data(odB), .out_addr(oaB));

  // SRAMs with one-cycle read latency; MAC with two-cycle latency.
  always @(posedge clk) begin
    frdA <= fm_mem[fraA];
    wrdA <= wt_mem[wraA];
    frdB <= fm_mem[fraB];
    wrdB <= wt_mem[wraB];
    if (rst) begin
      accA <= 8'd0; ansA <= 8'd0; accB <= 8'd0; ansB <= 8'd0;
    end else begin
      accA <= clrA ? 8'(mdA * mwA) : 8'(accA + mdA * mwA);
      accB <= clrB ? 8'(mdB * mwB) : 8'(accB + mdB * mwB);
      ansA <= accA;
      ansB <= accB;
    end
  end

  // Monitors: handshakes, clear strobes, done pulses, relative cycles.
  int qdA[$], qaA[$], qcA[$], qclA[$], qcdA[$];
  int qdB[$], qaB[$];
  int dnA = 0, dnB = 0;
  int sA = 0, sB = 0;
  int rfB [64];

  always @(negedge clk) begin
    if (!rst) begin
      if (startA && !busyA) sA = cyc;
      if (ovA && ordyA) begin
        qdA.push_back(int'(odA));
        qaA.push_back(int'(oaA));
        qcA.push_back(cyc - sA);
      end
      if (clrA) begin
        qclA.push_back(cyc - sA);
        qcdA.push_back(int'(mdA));
      end
      if (doneA) dnA++;
      if (startB && !busyB) sB = cyc;
      if (cyc - sB >= 0 && cyc - sB < 64) rfB[cyc - sB] = int'(fraB);
      if (ovB && ordyB) begin
        qdB.push_back(int'(odB));
        qaB.push_back(int'(oaB));
      end
      if (doneB) dnB++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic clear_mon();
    qdA.delete(); qaA.delete(); qcA.delete(); qclA.delete(); qcdA.delete();
    qdB.delete(); qaB.delete();
    dnA = 0; dnB = 0;
    for (int i = 0; i < 64; i++) rfB[i] = -1;
  endtask

  task automatic fill(input int fmm, input int wtm);
    for (int i = 0; i < 64; i++) begin
      case (fmm)
        0:       fm_mem[i] = 8'(i);
        1:       fm_mem[i] = 8'd1;
        2:       fm_mem[i] = 8'(2 * i);
        default: fm_mem[i] = 8'hff;
      endcase
    end
    for (int i = 0; i < 16; i++) begin
      if (wtm == 9)       wt_mem[i] = 8'd1;
      else if (wtm == 10) wt_mem[i] = 8'hff;
      else                wt_mem[i] = (i == wtm) ? 8'd1 : 8'd0;
    end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 64; i++) fm_mem[i] = 8'($urandom);
    for (int i = 0; i < 16; i++) wt_mem[i] = 8'($urandom);
  endtask

  // Reference: direct valid-padding 3x3 sum of products, mod 256.
  function automatic logic [7:0] ref_pix(input int w, input int r, input int c);
    int s;
    s = 0;
    for (int ky = 0; ky < 3; ky++)
      for (int kx = 0; kx < 3; kx++)
        s += int'(fm_mem[(r + ky) * w + c + kx]) * int'(wt_mem[ky * 3 + kx]);
    return 8'(s);
  endfunction

  task automatic wait_done(input bit sel, input int pct, input string nm);
    bit fin;
    fin = 1'b0;
    for (int n = 0; n < 600 && !fin; n++) begin
      if (sel) ordyB = ($urandom_range(99) < pct);
      else     ordyA = ($urandom_range(99) < pct);
      step();
      fin = sel ? (dnB != 0) : (dnA != 0);
    end
    ordyA = 1'b1;
    ordyB = 1'b1;
    chk({nm, "_done_seen"}, fin, 1);
    repeat (4) step();
  endtask

  task automatic run_pass(input bit sel, input int pct, input string nm);
    clear_mon();
    if (sel) startB = 1'b1;
    else     startA = 1'b1;
    step();
    startA = 1'b0;
    startB = 1'b0;
    wait_done(sel, pct, nm);
  endtask

  task automatic check_a4(input string nm, input logic [31:0] e);
    logic [31:0] ev;
    ev = e;
    chk({nm, "_count"}, qdA.size(), 4);
    chk({nm, "_done_cnt"}, dnA, 1);
    chk({nm, "_idle"}, busyA, 0);
    for (int j = 0; j < 4 && j < qdA.size(); j++) begin
      chk($sformatf("%s_data%0d", nm, j), qdA[j], ev[8*j +: 8]);
      chk($sformatf("%s_addr%0d", nm, j), qaA[j], j);
    end
  endtask

  task automatic check_ref(input bit sel, input int w, input int h, input string nm);
    int n;
    int d[$];
    int a[$];
    n = (w - 2) * (h - 2);
    if (sel) begin d = qdB; a = qaB; end
    else     begin d = qdA; a = qaA; end
    chk({nm, "_count"}, d.size(), n);
    chk({nm, "_done_cnt"}, sel ? dnB : dnA, 1);
    for (int j = 0; j < n && j < d.size(); j++) begin
      chk($sformatf("%s_data%0d", nm, j), d[j], ref_pix(w, j / (w - 2), j % (w - 2)));
      chk($sformatf("%s_addr%0d", nm, j), a[j], j);
    end
  endtask

  typedef struct {
    int              fmm;
    int              wtm;
    logic [3:0][7:0] e;
  } vec_t;

  vec_t tbl [6];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit ok;
    int bad;
    int tap_b [9];
    logic [7:0] d0;
    logic [5:0] a0, f0;

    tbl[0] = '{0, 4,  32'h0a090605};
    tbl[1] = '{1, 9,  32'h09090909};
    tbl[2] = '{0, 0,  32'h05040100};
    tbl[3] = '{0, 8,  32'h0f0e0b0a};
    tbl[4] = '{2, 9,  32'hb4a26c5a};
    tbl[5] = '{3, 10, 32'h09090909};
    tap_b = '{2, 3, 4, 7, 8, 9, 12, 13, 14};

    fill(0, 4);
    clear_mon();
    rst = 1'b1;
    repeat (3) step();
    chk("reset_outs_a",
        {busyA, doneA, fraA, wraA, clrA, mdA, mwA, ovA, odA, oaA}, 0);
    chk("reset_outs_b",
        {busyB, doneB, fraB, wraB, clrB, mdB, mwB, ovB, odB, oaB}, 0);
    rst = 1'b0;
    step();

    // Table-driven full passes on the 4x4 map.
    for (int t = 0; t < 6; t++) begin
      fill(tbl[t].fmm, tbl[t].wtm);
      run_pass(1'b0, 100, $sformatf("tbl%0d", t));
      check_a4($sformatf("tbl%0d", t), tbl[t].e);
      if (t == 0) begin
        if (qcA.size() > 0) chk("first_valid_cycle", qcA[0], 13);
        for (int j = 0; j < 4 && j < qcdA.size(); j++)
          chk($sformatf("clr_tap0_data%0d", j), qcdA[j], (j / 2) * 4 + (j % 2));
      end
      if (t == 1) begin
        chk("clr_count", qclA.size(), 4);
        for (int j = 0; j < 4 && j < qclA.size(); j++)
          chk($sformatf("clr_cycle%0d", j), qclA[j], 2 + 13 * j);
        for (int j = 0; j < 4 && j < qcA.size(); j++)
          chk($sformatf("out_cycle%0d", j), qcA[j], 13 + 13 * j);
      end
    end

    // Backpressure on output 1.
    fill(0, 4);
    clear_mon();
    startA = 1'b1;
    step();
    startA = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 60 && !ok; n++) begin
      step();
      ok = (oaA == 6'd1);
    end
    chk("bp_reach_out1", ok, 1);
    ordyA = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 40 && !ok; n++) begin
      step();
      ok = ovA;
    end
    chk("bp_valid", ok, 1);
    d0 = odA; a0 = oaA; f0 = fraA; bad = 0;
    repeat (20) begin
      step();
      if (ovA !== 1'b1 || odA !== d0 || oaA !== a0 || fraA !== f0) bad++;
    end
    chk("bp_stable", bad, 0);
    chk("bp_held_data", d0, 6);
    chk("bp_held_addr", a0, 1);
    wait_done(1'b0, 100, "bp");
    check_a4("bp", 32'h0a090605);

    // Reset during FETCH of output 2, then a fresh pass.
    clear_mon();
    startA = 1'b1;
    step();
    startA = 1'b0;
    repeat (28) step();
    rst = 1'b1;
    step();
    chk("rst_busy", busyA, 0);
    chk("rst_valid", ovA, 0);
    rst = 1'b0;
    repeat (30) step();
    chk("rst_no_done", dnA, 0);
    chk("rst_outs_before", qdA.size(), 2);
    run_pass(1'b0, 100, "rst_rerun");
    check_a4("rst_rerun", 32'h0a090605);

    // Start pulses in FETCH, DRAIN and OUT are ignored.
    clear_mon();
    startA = 1'b1;
    step();
    startA = 1'b0;
    ok = 1'b0;
    for (int n = 1; n < 300 && !ok; n++) begin
      startA = (n == 5 || n == 11 || n == 13);
      step();
      ok = (dnA != 0);
    end
    startA = 1'b0;
    chk("sb_done_seen", ok, 1);
    repeat (6) step();
    check_a4("sb", 32'h0a090605);

    // Non-square 5x3 map.
    fill(0, 4);
    run_pass(1'b1, 100, "ns");
    check_ref(1'b1, 5, 3, "ns");
    for (int k = 0; k < 9; k++)
      chk($sformatf("ns_tap_addr%0d", k), rfB[27 + k], tap_b[k]);

    // Random data, weights and ready pattern against the reference model.
    for (int it = 0; it < 4; it++) begin
      fill_rand();
      run_pass(1'b0, 70, $sformatf("rnd_a%0d", it));
      check_ref(1'b0, 4, 4, $sformatf("rnd_a%0d", it));
      run_pass(1'b1, 70, $sformatf("rnd_b%0d", it));
      check_ref(1'b1, 5, 3, $sformatf("rnd_b%0d", it));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
